// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU and result bus between the issue controller and its surroundings.
// The slave modport is the controller's view; master is the driving side.
interface alu_issue_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic [REG_ADDR_WIDTH-1:0] cmd_src0;
  logic [REG_ADDR_WIDTH-1:0] cmd_src1;
  logic [REG_ADDR_WIDTH-1:0] cmd_dst;
  logic                      cmd_use_imm;
  logic [DATA_WIDTH-1:0]     cmd_imm;

  logic [2:0]                alu_ctrl;
  logic [DATA_WIDTH-1:0]     alu_in0;
  logic [DATA_WIDTH-1:0]     alu_in1;
  logic [DATA_WIDTH-1:0]     alu_out;

  logic                      res_valid;
  logic [DATA_WIDTH-1:0]     res_data;
  logic [REG_ADDR_WIDTH-1:0] res_dst;

  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]     rd_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src0, cmd_src1, cmd_dst, cmd_use_imm, cmd_imm,
    input  alu_out, rd_addr,
    output cmd_ready, alu_ctrl, alu_in0, alu_in1,
    output res_valid, res_data, res_dst, rd_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src0, cmd_src1, cmd_dst, cmd_use_imm, cmd_imm,
    output alu_out, rd_addr,
    input  cmd_ready, alu_ctrl, alu_in0, alu_in1,
    input  res_valid, res_data, res_dst, rd_data
  );

endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-cycle issue controller: latches operands for an external combinational ALU
// from a small register file, then writes the ALU result back and reports it.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  alu_issue_ctrl_if.slave    bus
);

  localparam int NREGS = 2 ** REG_ADDR_WIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  logic [0:0]                state_q, state_d;
  logic                      readyEn_q;
  logic [2:0]                aluCtrl_q, aluCtrl_d;
  logic [DATA_WIDTH-1:0]     aluIn0_q, aluIn0_d;
  logic [DATA_WIDTH-1:0]     aluIn1_q, aluIn1_d;
  logic [REG_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic                      resValid_q, resValid_d;
  logic [DATA_WIDTH-1:0]     resData_q, resData_d;
  logic [REG_ADDR_WIDTH-1:0] resDst_q, resDst_d;
  logic [DATA_WIDTH-1:0]     regs_q [NREGS];
  logic                      wrEn;
  logic                      accept;

  // Register 0 is hardwired to zero on every read path.
  function automatic logic [DATA_WIDTH-1:0] readReg(input logic [REG_ADDR_WIDTH-1:0] addr);
    if (addr == '0) return '0;
    return regs_q[addr];
  endfunction

  assign bus.cmd_ready = readyEn_q && (state_q == IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign bus.alu_ctrl  = aluCtrl_q;
  assign bus.alu_in0   = aluIn0_q;
  assign bus.alu_in1   = aluIn1_q;
  assign bus.res_valid = resValid_q;
  assign bus.res_data  = resData_q;
  assign bus.res_dst   = resDst_q;
  assign bus.rd_data   = readReg(bus.rd_addr);

  always_comb begin
    state_d    = state_q;
    aluCtrl_d  = aluCtrl_q;
    aluIn0_d   = aluIn0_q;
    aluIn1_d   = aluIn1_q;
    dst_d      = dst_q;
    resValid_d = 1'b0;
    resData_d  = resData_q;
    resDst_d   = resDst_q;
    wrEn       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          aluCtrl_d = bus.cmd_op;
          aluIn0_d  = readReg(bus.cmd_src0);
          aluIn1_d  = bus.cmd_use_imm ? bus.cmd_imm : readReg(bus.cmd_src1);
          dst_d     = bus.cmd_dst;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        wrEn       = (dst_q != '0);
        resValid_d = 1'b1;
        resData_d  = bus.alu_out;
        resDst_d   = dst_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // readyEn_q holds off cmd_ready until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      readyEn_q  <= 1'b0;
      aluCtrl_q  <= '0;
      aluIn0_q   <= '0;
      aluIn1_q   <= '0;
      dst_q      <= '0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resDst_q   <= '0;
    end else begin
      state_q    <= state_d;
      readyEn_q  <= 1'b1;
      aluCtrl_q  <= aluCtrl_d;
      aluIn0_q   <= aluIn0_d;
      aluIn1_q   <= aluIn1_d;
      dst_q      <= dst_d;
      resValid_q <= resValid_d;
      resData_q  <= resData_d;
      resDst_q   <= resDst_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wrEn) begin
      regs_q[dst_q] <= bus.alu_out;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: stimulus pushes hand-computed results into a
// queue and an independent monitor pops and compares on every res_valid strobe.
module tb_alu_issue_ctrl;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  int   cycleCnt;
  logic [35:0] expQ [$];

  alu_issue_ctrl_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) bus ();

  alu_issue_ctrl #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // External ALU: 0 and, 1 add, 2 sub, 3 or, 4 signed lt, 5 unsigned lt, 6-7 zero.
  always_comb begin
    case (bus.alu_ctrl)
      3'd0:    bus.alu_out = bus.alu_in0 & bus.alu_in1;
      3'd1:    bus.alu_out = bus.alu_in0 + bus.alu_in1;
      3'd2:    bus.alu_out = bus.alu_in0 - bus.alu_in1;
      3'd3:    bus.alu_out = bus.alu_in0 | bus.alu_in1;
      3'd4:    bus.alu_out = {31'd0, $signed(bus.alu_in0) < $signed(bus.alu_in1)};
      3'd5:    bus.alu_out = {31'd0, bus.alu_in0 < bus.alu_in1};
      default: bus.alu_out = 32'd0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (bus.res_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedResult: got dst=%0d data=0x%08h, expected no result",
                 bus.res_dst, bus.res_data);
      end else begin
        logic [35:0] e;
        e = expQ.pop_front();
        checkOutput("resData", bus.res_data, e[31:0]);
        checkOutput("resDst", {28'd0, bus.res_dst}, {28'd0, e[35:32]});
      end
    end
  end

  // Presents a command from a negedge, returns at the negedge after it was accepted.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] src0, input logic [3:0] src1,
                               input logic [3:0] dst, input logic useImm, input logic [31:0] imm,
                               input logic expectRes, input logic [31:0] expData, input logic hold,
                               output int acceptCycle);
    int waitCnt;
    bus.cmd_op      = op;
    bus.cmd_src0    = src0;
    bus.cmd_src1    = src1;
    bus.cmd_dst     = dst;
    bus.cmd_use_imm = useImm;
    bus.cmd_imm     = imm;
    bus.cmd_valid   = 1'b1;
    waitCnt = 0;
    while (bus.cmd_ready !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    acceptCycle = cycleCnt;
    if (bus.cmd_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL acceptTimeout: got cmd_ready=%b, expected 1 within 20 cycles", bus.cmd_ready);
    end else if (expectRes) begin
      expQ.push_back({dst, expData});
    end
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drainTimeout: got %0d pending results, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic checkReg(input string name, input logic [3:0] addr, input logic [31:0] expected);
    bus.rd_addr = addr;
    #1;
    checkOutput(name, bus.rd_data, expected);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstCmdReady", {31'd0, bus.cmd_ready}, 32'd0);
    checkOutput("rstResValid", {31'd0, bus.res_valid}, 32'd0);
    checkOutput("rstResData", bus.res_data, 32'd0);
    checkOutput("rstResDst", {28'd0, bus.res_dst}, 32'd0);
    checkOutput("rstAluCtrl", {29'd0, bus.alu_ctrl}, 32'd0);
    checkOutput("rstAluIn0", bus.alu_in0, 32'd0);
    checkOutput("rstAluIn1", bus.alu_in1, 32'd0);
  endtask

  initial begin
    int a0, a1, tmp;
    total = 0;
    bad = 0;
    cycleCnt = 0;
    rstn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_src0 = '0;
    bus.cmd_src1 = '0;
    bus.cmd_dst = '0;
    bus.cmd_use_imm = 1'b0;
    bus.cmd_imm = '0;
    bus.rd_addr = '0;

    repeat (3) @(negedge clk);
    checkResetOutputs();
    for (int i = 0; i < 16; i++) checkReg("rstRdData", 4'(i), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterRst", {31'd0, bus.cmd_ready}, 32'd1);

    // Immediate add, then a register add issued back-to-back with valid held high.
    applyStimulus(3'd1, 4'd0, 4'd0, 4'd3, 1'b1, 32'd5, 1'b1, 32'd5, 1'b1, a0);
    applyStimulus(3'd1, 4'd3, 4'd3, 4'd4, 1'b0, 32'd0, 1'b1, 32'd10, 1'b0, a1);
    checkOutput("acceptSpacing", 32'(a1 - a0), 32'd2);
    waitDrain();
    checkReg("reg4", 4'd4, 32'd10);

    // Wrap-around subtract and signed/unsigned compares.
    applyStimulus(3'd2, 4'd1, 4'd0, 4'd2, 1'b1, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, tmp);
    applyStimulus(3'd4, 4'd2, 4'd0, 4'd6, 1'b1, 32'd1, 1'b1, 32'd1, 1'b0, tmp);
    applyStimulus(3'd5, 4'd2, 4'd0, 4'd7, 1'b1, 32'd1, 1'b1, 32'd0, 1'b0, tmp);
    applyStimulus(3'd6, 4'd3, 4'd0, 4'd10, 1'b1, 32'd7, 1'b1, 32'd0, 1'b0, tmp);
    waitDrain();
    checkReg("reg2", 4'd2, 32'hFFFF_FFFF);
    checkReg("reg6", 4'd6, 32'd1);
    checkReg("reg7", 4'd7, 32'd0);

    // Destination zero still reports the result but leaves reg0 at zero.
    applyStimulus(3'd1, 4'd0, 4'd0, 4'd0, 1'b1, 32'h1234, 1'b1, 32'h1234, 1'b0, tmp);
    waitDrain();
    checkReg("reg0", 4'd0, 32'd0);

    // Busy stall: a command offered in EXEC is replaced before the next IDLE cycle.
    applyStimulus(3'd1, 4'd3, 4'd0, 4'd8, 1'b1, 32'd1, 1'b1, 32'd6, 1'b1, tmp);
    bus.cmd_op = 3'd1;
    bus.cmd_src0 = 4'd0;
    bus.cmd_dst = 4'd9;
    bus.cmd_imm = 32'hDEAD;
    #1;
    checkOutput("stallReady", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    applyStimulus(3'd3, 4'd4, 4'd0, 4'd9, 1'b1, 32'h100, 1'b1, 32'h10A, 1'b0, tmp);
    checkOutput("stallAluCtrl", {29'd0, bus.alu_ctrl}, 32'd3);
    checkOutput("stallAluIn1", bus.alu_in1, 32'h100);
    waitDrain();
    checkReg("reg8", 4'd8, 32'd6);
    checkReg("reg9", 4'd9, 32'h10A);
    checkOutput("aluCtrlHold", {29'd0, bus.alu_ctrl}, 32'd3);

    // Reset in EXEC aborts the command.
    applyStimulus(3'd1, 4'd0, 4'd0, 4'd5, 1'b1, 32'd7, 1'b1, 32'd7, 1'b0, tmp);
    waitDrain();
    checkReg("reg5", 4'd5, 32'd7);
    applyStimulus(3'd1, 4'd5, 4'd0, 4'd5, 1'b1, 32'd1, 1'b0, 32'd0, 1'b0, tmp);
    rstn = 1'b0;
    #1;
    checkResetOutputs();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    checkReg("reg5AfterRst", 4'd5, 32'd0);
    @(negedge clk);
    checkOutput("readyAfterAbort", {31'd0, bus.cmd_ready}, 32'd1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
